// File: rtl/gullfaxi_pkg.sv
// Shared types and defaults for the Gullfaxi router port blocks.
package gullfaxi_pkg;

    localparam int LEN_W             = 6;
    localparam int DATA_W            = 8;
    localparam int DEF_MAX_LEN       = 63;
    localparam int DEF_FIFO_DEPTH    = 64;
    localparam int DEF_GRANT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RECV
    } sink_state_e;

    // One cycle of the router-to-port bundle.
    typedef struct packed {
        logic              req;
        logic              start;
        logic [LEN_W-1:0]  length;
        logic [DATA_W-1:0] data;
        logic              stop;
    } port_beat_t;

    // Word stored in the sink FIFO.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } fifo_word_t;

endpackage

// File: rtl/gullfaxi_port_sink_if.sv
// Router output port bundle plus the sink's ready/valid read stream.
interface gullfaxi_port_sink_if import gullfaxi_pkg::*; ();

    logic              O_start;
    logic [LEN_W-1:0]  O_length;
    logic [DATA_W-1:0] O_data;
    logic              O_end;
    logic              O_req;
    logic              O_grant;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_ready;

    // Router and consumer side.
    modport master (
        output O_start, O_length, O_data, O_end, O_req, rd_ready,
        input  O_grant, rd_valid, rd_data, rd_last
    );

    // Sink side.
    modport slave (
        input  O_start, O_length, O_data, O_end, O_req, rd_ready,
        output O_grant, rd_valid, rd_data, rd_last
    );

endinterface

// File: rtl/gullfaxi_sync_fifo.sv
// Synchronous first-word fall-through FIFO with extra-bit pointers.
module gullfaxi_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     free
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      used;
    logic             rd_fire;
    logic             wr_fire;

    assign used    = wr_ptr - rd_ptr;
    assign empty   = (used == '0);
    assign full    = (used == (AW+1)'(DEPTH));
    assign free    = (AW+1)'(DEPTH) - used;
    assign rd_fire = rd_en && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_fire = wr_en && (!full || rd_fire);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; emptiness is tracked by the pointers alone.
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/gullfaxi_port_sink.sv
// Receiving end of one Gullfaxi output port: grants, captures, length-checks
// and buffers packets for a ready/valid consumer.
module gullfaxi_port_sink import gullfaxi_pkg::*; #(
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int MAX_LEN       = DEF_MAX_LEN,
    parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    gullfaxi_port_sink_if.slave   bus,
    output logic [15:0]           pkt_cnt,
    output logic                  err_len,
    output logic                  err_proto
);

    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int TW  = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [FAW:0]  NEED_FREE = (FAW+1)'(MAX_LEN);
    localparam logic [TW-1:0] TIMER_END = TW'(GRANT_TIMEOUT - 1);

    port_beat_t       beat;
    sink_state_e      state_q, state_d;
    logic             grant_q, grant_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             ovl_q, ovl_d;
    logic             wr_en, pkt_done, len_err_d, proto_err_d, wr_drop;
    fifo_word_t       wr_word, rd_word;
    logic             fifo_full, fifo_empty;
    logic [FAW:0]     fifo_free;

    assign beat = '{req: bus.O_req, start: bus.O_start, length: bus.O_length,
                    data: bus.O_data, stop: bus.O_end};
    assign wr_word = '{last: beat.stop, data: beat.data};

    gullfaxi_sync_fifo #(
        .WIDTH ($bits(fifo_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_word),
        .rd_en   (bus.rd_ready),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .free    (fifo_free)
    );

    assign bus.rd_valid = !fifo_empty;
    assign bus.rd_data  = rd_word.data;
    assign bus.rd_last  = rd_word.last;
    assign bus.O_grant  = grant_q;
    // Only illegal traffic can hit a full FIFO; that byte is lost.
    assign wr_drop = wr_en && fifo_full && !(bus.rd_ready && !fifo_empty);

    // Next-state, capture and error decisions for the grant/receive FSM.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d     = state_q;
        grant_d     = grant_q;
        timer_d     = timer_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        ovl_d       = ovl_q;
        wr_en       = 1'b0;
        pkt_done    = 1'b0;
        len_err_d   = 1'b0;
        proto_err_d = 1'b0;
        cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);
        unique case (state_q)
            IDLE: begin
                if (beat.req && fifo_free >= NEED_FREE) begin
                    state_d = GRANT;
                    grant_d = 1'b1;
                    timer_d = '0;
                end
            end
            GRANT: begin
                if (beat.start) begin
                    wr_en   = 1'b1;
                    len_d   = beat.length;
                    cnt_d   = LEN_W'(1);
                    ovl_d   = 1'b0;
                    grant_d = 1'b0;
                    state_d = RECV;
                    if (beat.stop) begin
                        state_d = IDLE;
                        if (beat.length == LEN_W'(1)) pkt_done  = 1'b1;
                        else                          len_err_d = 1'b1;
                    end
                end else if (timer_q == TIMER_END) begin
                    proto_err_d = 1'b1;
                    grant_d     = 1'b0;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RECV: begin
                wr_en = 1'b1;
                cnt_d = cnt_inc;
                if (beat.start) proto_err_d = 1'b1;
                if (beat.stop) begin
                    state_d = IDLE;
                    // An overlength packet was already reported; no second pulse.
                    if (!ovl_q) begin
                        if (cnt_inc == len_q && len_q != '0) pkt_done  = 1'b1;
                        else                                 len_err_d = 1'b1;
                    end
                end else if (cnt_q == len_q && !ovl_q) begin
                    len_err_d = 1'b1;
                    ovl_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM registers, packet counter and registered error pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            timer_q   <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            ovl_q     <= 1'b0;
            pkt_cnt   <= '0;
            err_len   <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            timer_q   <= timer_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            ovl_q     <= ovl_d;
            if (pkt_done) pkt_cnt <= pkt_cnt + 16'd1;
            err_len   <= len_err_d;
            err_proto <= proto_err_d | wr_drop;
        end
    end

endmodule

// File: tb/tb_gullfaxi_port_sink.sv
// Self-checking bench for gullfaxi_port_sink: a router/consumer driver plus a
// packet-level reference model (expected byte queue, packet and error counts).
module tb_gullfaxi_port_sink;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pkt_cnt;
    logic        err_len;
    logic        err_proto;

    gullfaxi_port_sink_if ifc ();

    gullfaxi_port_sink dut (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (ifc),
        .pkt_cnt   (pkt_cnt),
        .err_len   (err_len),
        .err_proto (err_proto)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         err_len_seen = 0;
    int         err_proto_seen = 0;
    int         ready_mode = 1;   // 0: never, 1: always, 2: random
    int         exp_pkt = 0;
    logic [8:0] exp_q [$];

    // Advance to the next falling edge, account error pulses, drive rd_ready
    // for the coming rising edge and check any byte the consumer takes.
    task automatic step();
        logic [8:0] exp_word;
        @(negedge clk);
        if (err_len === 1'b1) err_len_seen++;
        if (err_proto === 1'b1) err_proto_seen++;
        case (ready_mode)
            0:       ifc.rd_ready = 1'b0;
            1:       ifc.rd_ready = 1'b1;
            default: ifc.rd_ready = ($urandom_range(0, 1) == 1);
        endcase
        if (rst_n && ifc.rd_valid === 1'b1 && ifc.rd_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_beat: got data=%h last=%b, expected no beat", ifc.rd_data, ifc.rd_last);
            end else begin
                exp_word = exp_q.pop_front();
                if ({ifc.rd_last, ifc.rd_data} !== exp_word) begin
                    fails++;
                    $display("FAIL rd_beat: got last=%b data=%h, expected last=%b data=%h",
                             ifc.rd_last, ifc.rd_data, exp_word[8], exp_word[7:0]);
                end
            end
        end
    endtask

    task automatic clear_inputs();
        ifc.O_start  = 1'b0;
        ifc.O_end    = 1'b0;
        ifc.O_length = '0;
        ifc.O_data   = '0;
    endtask

    // Request, wait for grant, send n bytes declaring length len, then check
    // error pulses and the packet counter against the packet rules.
    task automatic send_packet(input int len, input int n, input logic [7:0] first,
                               input bit rnd_data, input bit chk_latency);
        int         waits = 0;
        int         el0 = err_len_seen;
        int         ep0 = err_proto_seen;
        int         exp_err;
        bit         was_empty;
        logic [7:0] d;
        logic [7:0] d0 = '0;
        ifc.O_req = 1'b1;
        while (ifc.O_grant !== 1'b1 && waits < 400) begin
            step();
            waits++;
        end
        if (ifc.O_grant !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL grant_wait: no grant after %0d cycles, expected grant", waits);
            ifc.O_req = 1'b0;
            return;
        end
        if (chk_latency) begin
            tests++;
            if (waits != 1) begin
                fails++;
                $display("FAIL grant_latency: grant after %0d cycles, expected 1", waits);
            end
        end
        was_empty = (exp_q.size() == 0);
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                step();
                if (i == 1 && was_empty) begin
                    tests++;
                    if (ifc.rd_valid !== 1'b1 || ifc.rd_data !== d0) begin
                        fails++;
                        $display("FAIL rd_latency: valid=%b data=%h, expected valid=1 data=%h",
                                 ifc.rd_valid, ifc.rd_data, d0);
                    end
                end
            end
            if (i < n) begin
                d = rnd_data ? 8'($urandom) : first + 8'(i);
                if (i == 0) d0 = d;
                ifc.O_req    = 1'b0;
                ifc.O_start  = (i == 0);
                ifc.O_length = 6'(len);
                ifc.O_data   = d;
                ifc.O_end    = (i == n - 1);
                exp_q.push_back({(i == n - 1), d});
            end else begin
                clear_inputs();
            end
        end
        step();
        step();
        exp_err = (n == len && len != 0) ? 0 : 1;
        if (exp_err == 0) exp_pkt++;
        tests++;
        if (err_len_seen - el0 != exp_err) begin
            fails++;
            $display("FAIL err_len_count: got %0d pulses, expected %0d (len=%0d bytes=%0d)",
                     err_len_seen - el0, exp_err, len, n);
        end
        tests++;
        if (err_proto_seen != ep0) begin
            fails++;
            $display("FAIL err_proto_quiet: got %0d pulses, expected 0", err_proto_seen - ep0);
        end
        tests++;
        if (pkt_cnt !== 16'(exp_pkt)) begin
            fails++;
            $display("FAIL pkt_cnt: got %0d, expected %0d", pkt_cnt, exp_pkt);
        end
    endtask

    // Let the consumer empty the FIFO, then check the stream has stopped.
    task automatic drain();
        int guard = 0;
        if (ready_mode == 0) ready_mode = 1;
        while (exp_q.size() > 0 && guard < 500) begin
            step();
            guard++;
        end
        step();
        tests++;
        if (exp_q.size() != 0 || ifc.rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain: %0d bytes missing, rd_valid=%b, expected 0 and 0", exp_q.size(), ifc.rd_valid);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        ifc.O_req    = 1'b0;
        ifc.rd_ready = 1'b0;
        rst_n        = 1'b0;
        repeat (3) step();
        tests++;
        if (ifc.O_grant !== 1'b0 || ifc.rd_valid !== 1'b0 || pkt_cnt !== 16'd0 ||
            err_len !== 1'b0 || err_proto !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: grant=%b rd_valid=%b pkt_cnt=%0d err_len=%b err_proto=%b, expected all 0",
                     ifc.O_grant, ifc.rd_valid, pkt_cnt, err_len, err_proto);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        ready_mode = 1;
        send_packet(4, 4, 8'hA0, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_one_byte();
        ready_mode = 1;
        send_packet(1, 1, 8'h5A, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_len_mismatch();
        ready_mode = 0;
        send_packet(5, 3, 8'h30, 1'b0, 1'b1);
        drain();
        ready_mode = 1;
        send_packet(2, 4, 8'h40, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_backpressure();
        int grants = 0;
        int guard = 0;
        ready_mode = 0;
        send_packet(63, 63, 8'h00, 1'b1, 1'b1);
        ifc.O_req = 1'b1;
        repeat (30) begin
            step();
            if (ifc.O_grant === 1'b1) grants++;
        end
        tests++;
        if (grants != 0) begin
            fails++;
            $display("FAIL bp_no_grant: grant seen %0d cycles with 1 free entry, expected 0", grants);
        end
        ready_mode = 1;
        while (ifc.O_grant !== 1'b1 && guard < 200) begin
            step();
            guard++;
        end
        tests++;
        if (ifc.O_grant !== 1'b1 || exp_q.size() > 1) begin
            fails++;
            $display("FAIL bp_regrant: grant=%b with %0d bytes queued, expected 1 with at most 1", ifc.O_grant, exp_q.size());
        end
        send_packet(3, 3, 8'hC0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_timeout();
        int guard = 0;
        int high = 0;
        int low = 0;
        int ep0;
        ready_mode = 1;
        ifc.O_req = 1'b1;
        while (ifc.O_grant !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        ep0 = err_proto_seen;
        while (ifc.O_grant === 1'b1 && high < 100) begin
            high++;
            step();
        end
        tests++;
        if (high != 16) begin
            fails++;
            $display("FAIL timeout_len: grant high %0d cycles, expected 16", high);
        end
        tests++;
        if (err_proto_seen - ep0 != 1) begin
            fails++;
            $display("FAIL timeout_err: got %0d err_proto pulses, expected 1", err_proto_seen - ep0);
        end
        while (ifc.O_grant !== 1'b1 && low < 50) begin
            step();
            low++;
        end
        tests++;
        if (low != 1) begin
            fails++;
            $display("FAIL timeout_regrant: grant low %0d cycles, expected 1", low);
        end
        send_packet(2, 2, 8'h70, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_random();
        int len;
        int n;
        int kind;
        ready_mode = 2;
        for (int k = 0; k < 12; k++) begin
            len  = $urandom_range(0, 20);
            kind = $urandom_range(0, 3);
            if (kind <= 1)      n = (len == 0) ? 1 : len;
            else if (kind == 2) n = len + 1 + $urandom_range(0, 3);
            else                n = $urandom_range(1, (len > 1) ? len - 1 : 1);
            send_packet(len, n, 8'h00, 1'b1, 1'b0);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        ready_mode = 0;
        ifc.O_req = 1'b1;
        while (ifc.O_grant !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            ifc.O_req    = 1'b0;
            ifc.O_start  = (i == 0);
            ifc.O_length = 6'd10;
            ifc.O_data   = 8'h90 + 8'(i);
            ifc.O_end    = 1'b0;
        end
        rst_n = 1'b0;
        step();
        tests++;
        if (ifc.O_grant !== 1'b0 || ifc.rd_valid !== 1'b0 || pkt_cnt !== 16'd0 || err_len !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: grant=%b rd_valid=%b pkt_cnt=%0d err_len=%b, expected all 0",
                     ifc.O_grant, ifc.rd_valid, pkt_cnt, err_len);
        end
        clear_inputs();
        exp_q.delete();
        exp_pkt = 0;
        rst_n   = 1'b1;
        step();
        ready_mode = 1;
        send_packet(3, 3, 8'hE0, 1'b0, 1'b1);
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_one_byte();
        test_len_mismatch();
        test_backpressure();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
